// File: rtl/packet_tx_framer.sv
// Drain stage of the packet buffer: pops one stored packet at a time and sends it on a
// GMII-style byte interface with preamble/SFD framing, illegal-length discard and IFG spacing.
module packet_tx_framer #(
    parameter int pDATA_WIDTH        = 8,
    parameter int pMIN_PACKET_LENGHT = 64,
    parameter int pMAX_PACKET_LENGHT = 1536,
    parameter int pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGHT) + 1,
    parameter int pIFG_CYCLES        = 12
) (
    input  logic                   iclk,
    input  logic                   i_rst_n,
    input  logic                   iempty,
    input  logic [pLEN_WIDTH-1:0]  ilen_pac,
    input  logic [pDATA_WIDTH-1:0] ird_data,
    input  logic                   itx_hold,
    output logic                   olen_pop,
    output logic                   ord_en,
    output logic [pDATA_WIDTH-1:0] otxd,
    output logic                   otx_en,
    output logic                   obusy,
    output logic                   oerr_len,
    output logic [15:0]            opkt_cnt,
    output logic [15:0]            odrop_cnt
);

    localparam logic [pLEN_WIDTH-1:0]  MIN_LEN  = pLEN_WIDTH'(pMIN_PACKET_LENGHT);
    localparam logic [pLEN_WIDTH-1:0]  MAX_LEN  = pLEN_WIDTH'(pMAX_PACKET_LENGHT);
    localparam logic [pLEN_WIDTH-1:0]  PRE_LAST = pLEN_WIDTH'(6);
    localparam logic [pLEN_WIDTH-1:0]  IFG_LAST = pLEN_WIDTH'(pIFG_CYCLES - 1);
    localparam logic [pDATA_WIDTH-1:0] PRE_BYTE = pDATA_WIDTH'(8'h55);
    localparam logic [pDATA_WIDTH-1:0] SFD_BYTE = pDATA_WIDTH'(8'hD5);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_DISCARD,
        ST_IFG
    } state_t;

    state_t                   state, state_nxt;
    logic [pLEN_WIDTH-1:0]    cnt, cnt_nxt, cnt_inc, rlen;
    logic                     tx_en_p0, pop_p0, err_p0, pkt_inc_p0, drop_inc_p0;
    logic [pDATA_WIDTH-1:0]   txd_p0;

    function automatic logic len_legal(input logic [pLEN_WIDTH-1:0] len);
        return (len >= MIN_LEN) && (len <= MAX_LEN);
    endfunction

    assign cnt_inc = cnt + 1'b1;
    assign obusy   = (state != ST_IDLE);

    // Stage p0: state decode. DATA holds one extra cycle (cnt == rlen) so the last byte
    // clears the output register before IFG starts counting.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt_inc;
        ord_en      = 1'b0;
        tx_en_p0    = 1'b0;
        txd_p0      = '0;
        pop_p0      = 1'b0;
        err_p0      = 1'b0;
        pkt_inc_p0  = 1'b0;
        drop_inc_p0 = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (!iempty && !itx_hold) begin
                    pop_p0 = 1'b1;
                    if (len_legal(ilen_pac)) begin
                        state_nxt = ST_PREAMBLE;
                    end else begin
                        state_nxt = ST_DISCARD;
                        err_p0    = 1'b1;
                    end
                end
            end
            ST_PREAMBLE: begin
                tx_en_p0 = 1'b1;
                txd_p0   = PRE_BYTE;
                if (cnt == PRE_LAST) begin
                    state_nxt = ST_SFD;
                    cnt_nxt   = '0;
                end
            end
            ST_SFD: begin
                // First read issued here: SRAM latency plus output register lands byte 1
                // right after the SFD.
                tx_en_p0  = 1'b1;
                txd_p0    = SFD_BYTE;
                ord_en    = 1'b1;
                state_nxt = ST_DATA;
                cnt_nxt   = '0;
            end
            ST_DATA: begin
                if (cnt == rlen) begin
                    state_nxt  = ST_IFG;
                    cnt_nxt    = '0;
                    pkt_inc_p0 = 1'b1;
                end else begin
                    tx_en_p0 = 1'b1;
                    txd_p0   = ird_data;
                    ord_en   = (cnt_inc != rlen);
                end
            end
            ST_DISCARD: begin
                if (cnt == rlen) begin
                    state_nxt   = ST_IFG;
                    cnt_nxt     = '0;
                    drop_inc_p0 = 1'b1;
                end else begin
                    ord_en = 1'b1;
                end
            end
            ST_IFG: begin
                if (cnt == IFG_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Stage p1: registered outputs and counters
    always_ff @(posedge iclk) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            olen_pop  <= 1'b0;
            oerr_len  <= 1'b0;
            otx_en    <= 1'b0;
            otxd      <= '0;
            opkt_cnt  <= '0;
            odrop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            olen_pop <= pop_p0;
            oerr_len <= err_p0;
            otx_en   <= tx_en_p0;
            otxd     <= txd_p0;
            if (pkt_inc_p0) opkt_cnt <= opkt_cnt + 16'd1;
            if (drop_inc_p0) odrop_cnt <= odrop_cnt + 16'd1;
        end
    end

    // Length is held while idle so the decision cycle's value sticks for the packet
    always_ff @(posedge iclk) begin
        if (state == ST_IDLE) rlen <= ilen_pac;
    end

endmodule
